rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Round-robin arbiter that shares the register file's single write port among NUM_REQ writeback requesters, such as the ALU, the load unit and the multiplier.
- Accepts one request per cycle using a valid/ready handshake.
- Registers the winning write into the register-file write port: reg_write, waddr and wdata.
- Drops writes to x0, counts contention, and can optionally forward the in-flight write to read ports.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- AW, 5, register address width.
- DW, 32, data width.
- CNT_W, 16, width of the contention counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wb_hold  in  1  pipeline hold; while high, no grant is issued.
- req_valid  in  NUM_REQ  per-requester write request.
- req_waddr  in  NUM_REQ*AW  packed destination indices; requester i occupies bits [i*AW +: AW].
- req_wdata  in  NUM_REQ*DW  packed write data; requester i occupies bits [i*DW +: DW].
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- rf_reg_write  out  1  registered write enable to the register file.
- rf_waddr  out  AW  registered write index.
- rf_wdata  out  DW  registered write data.
- x0_drop  out  1  registered one-cycle pulse: the accepted write targeted x0.
- contention_cnt  out  CNT_W  saturating count of contended cycles.
- byp_raddr1, byp_raddr2  in  AW each  read indices for bypass (present only with RF_WB_BYPASS_EN).
- byp_hit1, byp_hit2  out  1 each  bypass hit (present only with RF_WB_BYPASS_EN).
- byp_data1, byp_data2  out  DW each  bypass data (present only with RF_WB_BYPASS_EN).

Behaviour:
- Reset (asynchronous, active-high):
  - rf_reg_write=0, rf_waddr=0, rf_wdata=0, x0_drop=0, contention_cnt=0, rr_ptr=0.
  - Reset mid-operation discards the in-flight registered write.
- Grant (combinational):
  - If wb_hold=0, grant the first i with req_valid[i]=1, scanning cyclically from rr_ptr.
  - req_ready is one-hot on the winner and all-zero when there is no valid request or wb_hold=1.
  - A transfer (fire) occurs when req_valid[i] & req_ready[i].
- Requester rules:
  - A requester must hold valid, waddr and wdata stable until it is granted.
  - It may not drop valid before the grant; the bench checks both with assertions.
- Pipeline, one cycle latency. On the edge after a fire:
  - rf_reg_write <= (waddr != 0).
  - rf_waddr <= waddr.
  - rf_wdata <= wdata.
  - x0_drop <= (waddr == 0).
- When there is no fire:
  - rf_reg_write <= 0 and x0_drop <= 0.
  - rf_waddr and rf_wdata hold their previous values.
- Round-robin pointer:
  - On a fire, rr_ptr <= (granted index + 1) mod NUM_REQ.
  - Otherwise rr_ptr is unchanged; wb_hold freezes it.
- Fairness:
  - Any continuously valid requester is granted within NUM_REQ fire cycles.
- x0 writes:
  - Always accepted (ready asserted) so the requester drains.
  - Never produce rf_reg_write=1.
- Contention counter:
  - Increments on each cycle where wb_hold=0 and at least 2 bits of req_valid are set.
  - Saturates at all-ones and does not wrap.
- Single requester: a lone valid requester is granted every cycle regardless of rr_ptr.
- Ordering: back-to-back fires to the same waddr land in grant order, so the last grant wins in the register file.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- With the macro defined:
  - The bypass ports exist.
  - byp_hitN = rf_reg_write & (rf_waddr == byp_raddrN) & (byp_raddrN != 0).
  - byp_dataN = rf_wdata when byp_hitN=1, else 0.
  - Both outputs are purely combinational from the registered stage, so a read in the same cycle as the register-file write sees the new value.
- Without the macro: the bypass ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Reset, then a single requester: reset high with req_valid=3'b001 -> req_ready=0 during reset and all outputs 0. Release reset with req0 {waddr=5, wdata=0xDEADBEEF} -> req_ready=3'b001; next cycle rf_reg_write=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
- Round-robin: req_valid=3'b111 held for 6 cycles from rr_ptr=0 -> grant order 0,1,2,0,1,2; contention_cnt=6.
- x0 drop: req1 {waddr=0, wdata=0x1234} -> req_ready[1]=1; next cycle rf_reg_write=0, x0_drop=1, rr_ptr=2.
- Hold: wb_hold=1 for 3 cycles with req_valid=3'b110 -> req_ready=0, rf_reg_write=0, rr_ptr unchanged, contention_cnt unchanged. After release -> req1 is granted first.
- Async reset mid-write: assert reset between edges while rf_reg_write=1 -> rf_reg_write drops to 0 immediately without waiting for a clock edge; rr_ptr=0.
- Bypass (RF_WB_BYPASS_EN): fire waddr=7, wdata=0xA5A5A5A5, then set byp_raddr1=7 and byp_raddr2=0 -> byp_hit1=1, byp_data1=0xA5A5A5A5, byp_hit2=0, byp_data2=0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Round-robin arbiter sharing the register file's single write
//            port among NUM_REQ writeback requesters (ALU, load, mul, ...).
//            The winning write is registered onto the write port with one
//            cycle of latency. Writes to x0 are accepted but dropped, and
//            cycles with two or more competing requesters are counted.
// Ports    : clk, reset (async, active-high), wb_hold (blocks grants)
//            req_valid/req_waddr/req_wdata -> packed per-requester requests
//            req_ready      -> one-hot combinational grant
//            rf_reg_write/rf_waddr/rf_wdata -> registered write port
//            x0_drop        -> one-cycle pulse, accepted write hit x0
//            contention_cnt -> saturating count of contended cycles
//            byp_raddrN/byp_hitN/byp_dataN -> bypass of the in-flight write
// Options  : RF_WB_BYPASS_EN adds the two bypass read ports.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_hold,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_waddr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rf_reg_write,
  output logic [AW-1:0]         rf_waddr,
  output logic [DW-1:0]         rf_wdata,
  output logic                  x0_drop,
  output logic [CNT_W-1:0]      contention_cnt
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [AW-1:0]         byp_raddr1,
  input  logic [AW-1:0]         byp_raddr2,
  output logic                  byp_hit1,
  output logic                  byp_hit2,
  output logic [DW-1:0]         byp_data1,
  output logic [DW-1:0]         byp_data2
`endif
);

  localparam int              PTR_W    = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0] rr_ptr_q,         rr_ptr_d;
  logic             rf_reg_write_q,   rf_reg_write_d;
  logic [AW-1:0]    rf_waddr_q,       rf_waddr_d;
  logic [DW-1:0]    rf_wdata_q,       rf_wdata_d;
  logic             x0_drop_q,        x0_drop_d;
  logic [CNT_W-1:0] contention_cnt_q, contention_cnt_d;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;
  logic [AW-1:0]      win_waddr;
  logic [DW-1:0]      win_wdata;
  logic               fire;
  logic               contended;

  // Cyclic priority search starting at rr_ptr, done as two linear passes:
  // first the indices at or above the pointer, then wrap to the bottom.
  always_comb begin
    grant     = '0;
    win_idx   = '0;
    win_found = 1'b0;
    win_waddr = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[i] && (PTR_W'(i) >= rr_ptr_q)) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_found && (PTR_W'(i) == win_idx)) begin
        grant[i]  = 1'b1;
        win_waddr = req_waddr[i*AW +: AW];
        win_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  // No grant while held or in reset, so a requester never sees a handshake
  // that the registered stage would then discard.
  assign req_ready = (wb_hold || reset) ? '0 : grant;
  assign fire      = |req_ready;

  // v & (v-1) clears the lowest set bit; non-zero means two or more valid.
  assign contended = !wb_hold &&
                     (|(req_valid & (req_valid - NUM_REQ'(1))));

  always_comb begin
    rr_ptr_d         = rr_ptr_q;
    rf_reg_write_d   = 1'b0;
    rf_waddr_d       = rf_waddr_q;
    rf_wdata_d       = rf_wdata_q;
    x0_drop_d        = 1'b0;
    contention_cnt_d = contention_cnt_q;

    if (fire) begin
      // x0 writes drain the requester but never reach the register file.
      rf_reg_write_d = (win_waddr != '0);
      x0_drop_d      = (win_waddr == '0);
      rf_waddr_d     = win_waddr;
      rf_wdata_d     = win_wdata;
      rr_ptr_d       = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
    end

    if (contended && (contention_cnt_q != '1)) begin
      contention_cnt_d = contention_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q         <= '0;
      rf_reg_write_q   <= 1'b0;
      rf_waddr_q       <= '0;
      rf_wdata_q       <= '0;
      x0_drop_q        <= 1'b0;
      contention_cnt_q <= '0;
    end else begin
      rr_ptr_q         <= rr_ptr_d;
      rf_reg_write_q   <= rf_reg_write_d;
      rf_waddr_q       <= rf_waddr_d;
      rf_wdata_q       <= rf_wdata_d;
      x0_drop_q        <= x0_drop_d;
      contention_cnt_q <= contention_cnt_d;
    end
  end

  assign rf_reg_write   = rf_reg_write_q;
  assign rf_waddr       = rf_waddr_q;
  assign rf_wdata       = rf_wdata_q;
  assign x0_drop        = x0_drop_q;
  assign contention_cnt = contention_cnt_q;

`ifdef RF_WB_BYPASS_EN
  // Forward the write currently on the port so a same-cycle read of that
  // register sees the new value. x0 never hits.
  always_comb begin
    byp_hit1  = rf_reg_write_q && (rf_waddr_q == byp_raddr1) && (byp_raddr1 != '0);
    byp_hit2  = rf_reg_write_q && (rf_waddr_q == byp_raddr2) && (byp_raddr2 != '0);
    byp_data1 = byp_hit1 ? rf_wdata_q : '0;
    byp_data2 = byp_hit2 ? rf_wdata_q : '0;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Purpose  : Self-checking bench for rf_wb_arbiter. Directed scenarios plus
//            a randomized run compared against a queue-free behavioural
//            model (cyclic scan from a pointer, plain arithmetic). A small
//            counter width is used so saturation is reachable quickly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            wb_hold;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_waddr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic            rf_reg_write;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic            x0_drop;
  logic [CW-1:0]   contention_cnt;
`ifdef RF_WB_BYPASS_EN
  logic [AW-1:0]   byp_raddr1, byp_raddr2;
  logic            byp_hit1, byp_hit2;
  logic [DW-1:0]   byp_data1, byp_data2;
`endif

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .wb_hold(wb_hold),
    .req_valid(req_valid), .req_waddr(req_waddr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rf_reg_write(rf_reg_write), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .x0_drop(x0_drop), .contention_cnt(contention_cnt)
`ifdef RF_WB_BYPASS_EN
    , .byp_raddr1(byp_raddr1), .byp_raddr2(byp_raddr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int            m_ptr;
  logic          m_we, m_x0;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  int            m_cnt;
  int            last_grant;
  logic          rules_en = 1'b0;

  // Requester protocol: a pending (valid, not granted) request stays valid
  // and stable on the next edge.
  for (genvar gi = 0; gi < N; gi++) begin : g_rules
    a_stable: assert property (@(posedge clk) disable iff (reset || !rules_en)
      (req_valid[gi] && !req_ready[gi]) |=>
        (req_valid[gi] && $stable(req_waddr[gi*AW +: AW]) && $stable(req_wdata[gi*DW +: DW])))
      else $error("FAIL requester %0d dropped or changed a pending request", gi);
  end

  function automatic int model_grant();
    if (reset || wb_hold) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int g);
    if (g < 0) return '0;
    return N'(1) << g;
  endfunction

  task automatic set_req(int i, logic v, logic [AW-1:0] a, logic [DW-1:0] d);
    req_valid[i] = v;
    req_waddr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_we = 0; m_x0 = 0; m_waddr = '0; m_wdata = '0; m_cnt = 0;
    last_grant = -1;
  endtask

  // Advance model with the current inputs, then take one clock edge.
  task automatic tick();
    int g;
    g = model_grant();
    if (!wb_hold && $countones(req_valid) >= 2 && m_cnt < CNT_MAX) m_cnt++;
    if (g >= 0) begin
      m_waddr = req_waddr[g*AW +: AW];
      m_wdata = req_wdata[g*DW +: DW];
      m_we    = (m_waddr != 0);
      m_x0    = (m_waddr == 0);
      m_ptr   = (g + 1) % N;
    end else begin
      m_we = 0;
      m_x0 = 0;
    end
    last_grant = g;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; wb_hold = 1'b0;
    req_valid = '0; req_waddr = '0; req_wdata = '0;
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    checks++;
    if (req_ready !== 3'b000) begin
      errors++; $display("FAIL reset_ready: got %b want 000", req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({rf_reg_write, rf_waddr, rf_wdata, x0_drop, contention_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b a=%0d d=%h x0=%b cnt=%0d want all 0",
               rf_reg_write, rf_waddr, rf_wdata, x0_drop, contention_cnt);
    end
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++; $display("FAIL single_ready: got %b want 001", req_ready);
    end
    tick();
    req_valid = '0;
    checks++;
    if ({rf_reg_write, rf_waddr, rf_wdata, x0_drop} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b0}) begin
      errors++;
      $display("FAIL single_write: got we=%b a=%0d d=%h x0=%b want we=1 a=5 d=deadbeef x0=0",
               rf_reg_write, rf_waddr, rf_wdata, x0_drop);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), $urandom);
    for (int c = 0; c < 6; c++) begin
      #1;
      want = N'(1) << (c % N);
      checks++;
      if (req_ready !== want) begin
        errors++; $display("FAIL rr_order cycle %0d: got %b want %b", c, req_ready, want);
      end
      tick();
      checks++;
      if ({rf_reg_write, rf_waddr, rf_wdata} !== {1'b1, AW'((c % N) + 1), req_wdata[(c % N)*DW +: DW]}) begin
        errors++;
        $display("FAIL rr_write cycle %0d: got we=%b a=%0d d=%h want we=1 a=%0d",
                 c, rf_reg_write, rf_waddr, rf_wdata, (c % N) + 1);
      end
    end
    checks++;
    if (contention_cnt !== CW'(6)) begin
      errors++; $display("FAIL rr_contention: got %0d want 6", contention_cnt);
    end
  endtask

  task automatic test_saturation();
    repeat (12) tick();
    checks++;
    if (contention_cnt !== CW'(CNT_MAX)) begin
      errors++; $display("FAIL cnt_saturate: got %0d want %0d", contention_cnt, CNT_MAX);
    end
    tick();
    checks++;
    if (contention_cnt !== CW'(CNT_MAX)) begin
      errors++; $display("FAIL cnt_no_wrap: got %0d want %0d", contention_cnt, CNT_MAX);
    end
  endtask

  task automatic test_x0_drop();
    // 19 fires of 3 requesters so far: pointer sits at 1
    req_valid = '0;
    set_req(1, 1'b1, 5'd0, 32'h1234);
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++; $display("FAIL x0_ready: got %b want 010", req_ready);
    end
    tick();
    checks++;
    if ({rf_reg_write, x0_drop, rf_waddr, rf_wdata} !== {1'b0, 1'b1, 5'd0, 32'h1234}) begin
      errors++;
      $display("FAIL x0_write: got we=%b x0=%b a=%0d d=%h want we=0 x0=1 a=0 d=1234",
               rf_reg_write, x0_drop, rf_waddr, rf_wdata);
    end
    req_valid = 3'b111;
    #1;
    checks++;
    if (req_ready !== 3'b100) begin
      errors++; $display("FAIL x0_ptr: got %b want 100", req_ready);
    end
    tick();
    checks++;
    if (x0_drop !== 1'b0) begin
      errors++; $display("FAIL x0_pulse: got %b want 0", x0_drop);
    end
  endtask

  task automatic test_hold();
    do_reset();
    req_valid = '0;
    set_req(1, 1'b1, 5'd11, 32'h1111_0001);
    set_req(2, 1'b1, 5'd12, 32'h2222_0002);
    wb_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (req_ready !== 3'b000) begin
        errors++; $display("FAIL hold_ready cycle %0d: got %b want 000", c, req_ready);
      end
      tick();
      checks++;
      if ({rf_reg_write, contention_cnt} !== {1'b0, CW'(0)}) begin
        errors++;
        $display("FAIL hold_state cycle %0d: got we=%b cnt=%0d want we=0 cnt=0",
                 c, rf_reg_write, contention_cnt);
      end
    end
    wb_hold = 1'b0;
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++; $display("FAIL hold_release: got %b want 010", req_ready);
    end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    req_valid = '0;
    set_req(1, 1'b1, 5'd9, 32'h0BADF00D);
    tick();
    req_valid = '0;
    checks++;
    if ({rf_reg_write, rf_waddr} !== {1'b1, 5'd9}) begin
      errors++; $display("FAIL areset_pre: got we=%b a=%0d want we=1 a=9", rf_reg_write, rf_waddr);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({rf_reg_write, rf_waddr, rf_wdata, x0_drop} !== '0) begin
      errors++;
      $display("FAIL areset_clear: got we=%b a=%0d d=%h x0=%b want all 0",
               rf_reg_write, rf_waddr, rf_wdata, x0_drop);
    end
    #1;
    reset = 1'b0;
    model_reset();
    req_valid = 3'b111;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++; $display("FAIL areset_ptr: got %b want 001", req_ready);
    end
    @(posedge clk); #1;
    model_reset();
    do_reset();
  endtask

`ifdef RF_WB_BYPASS_EN
  task automatic test_bypass();
    byp_raddr1 = '0; byp_raddr2 = '0;
    req_valid = '0;
    set_req(0, 1'b1, 5'd7, 32'hA5A5A5A5);
    tick();
    req_valid = '0;
    byp_raddr1 = 5'd7; byp_raddr2 = 5'd0;
    #1;
    checks++;
    if ({byp_hit1, byp_data1, byp_hit2, byp_data2} !== {1'b1, 32'hA5A5A5A5, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL bypass_hit: got h1=%b d1=%h h2=%b d2=%h want h1=1 d1=a5a5a5a5 h2=0 d2=0",
               byp_hit1, byp_data1, byp_hit2, byp_data2);
    end
    tick();
    checks++;
    if ({byp_hit1, byp_data1} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL bypass_idle: got h1=%b d1=%h want 0", byp_hit1, byp_data1);
    end
    byp_raddr1 = '0;
  endtask
`endif

  task automatic test_random();
    int waitf [N];
    int g;
    for (int i = 0; i < N; i++) waitf[i] = 0;
    req_valid = '0; wb_hold = 1'b0;
    @(posedge clk); #1;
    last_grant = -1;
    rules_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && last_grant != i)) begin
          if ($urandom_range(0, 99) < 60)
            set_req(i, 1'b1, ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom), $urandom);
          else
            req_valid[i] = 1'b0;
        end
      end
      wb_hold = ($urandom_range(0, 4) == 0);
      #1;
      g = model_grant();
      checks++;
      if (req_ready !== onehot(g)) begin
        errors++; $display("FAIL rand_ready cycle %0d: got %b want %b", c, req_ready, onehot(g));
      end
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          checks++;
          if (waitf[i] >= N) begin
            errors++; $display("FAIL fairness req %0d: waited %0d fires, want < %0d", i, waitf[i], N);
          end
          waitf[i] = 0;
        end else if (req_valid[i] && |req_ready) begin
          waitf[i]++;
        end else if (!req_valid[i]) begin
          waitf[i] = 0;
        end
      end
      tick();
      checks++;
      if ({rf_reg_write, rf_waddr, rf_wdata, x0_drop, contention_cnt} !==
          {m_we, m_waddr, m_wdata, m_x0, CW'(m_cnt)}) begin
        errors++;
        $display("FAIL rand_out cycle %0d: got we=%b a=%0d d=%h x0=%b cnt=%0d want we=%b a=%0d d=%h x0=%b cnt=%0d",
                 c, rf_reg_write, rf_waddr, rf_wdata, x0_drop, contention_cnt,
                 m_we, m_waddr, m_wdata, m_x0, m_cnt);
      end
    end
    rules_en = 1'b0;
    req_valid = '0; wb_hold = 1'b0;
  endtask

  initial begin
`ifdef RF_WB_BYPASS_EN
    byp_raddr1 = '0; byp_raddr2 = '0;
`endif
    test_reset();
    test_round_robin();
    test_saturation();
    test_x0_drop();
    test_hold();
    test_async_reset();
`ifdef RF_WB_BYPASS_EN
    test_bypass();
`endif
    do_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
